// File: rtl/shared_memory_arbiter.sv
// Two-to-one arbiter sharing one single-ported memory between instruction fetch
// and the data side; one outstanding transaction, D priority with bounded I starvation.
module shared_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MAX_WAIT     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_read,
  input  logic [ADDRESS_BITS-1:0]   i_address_in,
  output logic                      i_ready,
  output logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     i_data_out,
  output logic [ADDRESS_BITS-1:0]   i_address_out,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_address_in,
  input  logic [DATA_WIDTH-1:0]     d_data_in,
  output logic                      d_ready,
  output logic                      d_valid,
  output logic [DATA_WIDTH-1:0]     d_data_out,
  output logic [ADDRESS_BITS-1:0]   d_address_out,
  output logic                      m_read,
  output logic                      m_write,
  output logic [DATA_WIDTH/8-1:0]   m_byte_en,
  output logic [ADDRESS_BITS-1:0]   m_address_out,
  output logic [DATA_WIDTH-1:0]     m_data_out,
  input  logic                      m_ready,
  input  logic                      m_valid,
  input  logic [DATA_WIDTH-1:0]     m_data_in,
  input  logic [ADDRESS_BITS-1:0]   m_address_in
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                    state_q, state_d;
  logic                      owner_d_q, owner_d_d;
  logic                      wr_q, wr_d;
  logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BE_W-1:0]           be_q, be_d;
  logic [CNT_W-1:0]          lose_cnt_q, lose_cnt_d;
  logic                      i_valid_q, i_valid_d;
  logic [DATA_WIDTH-1:0]     i_data_q, i_data_d;
  logic [ADDRESS_BITS-1:0]   i_addr_q, i_addr_d;
  logic                      d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]     d_data_q, d_data_d;
  logic [ADDRESS_BITS-1:0]   d_addr_q, d_addr_d;
  logic                      d_req, i_wins, grant_i, grant_d;

  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    lose_cnt_d = lose_cnt_q;
    i_valid_d  = 1'b0;
    i_data_d   = i_data_q;
    i_addr_d   = i_addr_q;
    d_valid_d  = 1'b0;
    d_data_d   = d_data_q;
    d_addr_d   = d_addr_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    d_req      = d_read | d_write;
    // I wins when alone, or when contested after MAX_WAIT consecutive losses
    i_wins     = i_read & (~d_req | (lose_cnt_q == CNT_W'(MAX_WAIT)));

    case (state_q)
      IDLE: begin
        if (!reset) begin
          grant_i = i_wins;
          grant_d = d_req & ~i_wins;
        end
        if (grant_i) begin
          owner_d_d  = 1'b0;
          wr_d       = 1'b0;
          addr_d     = i_address_in;
          be_d       = '1;
          lose_cnt_d = '0;
          state_d    = ISSUE;
        end else if (grant_d) begin
          owner_d_d  = 1'b1;
          wr_d       = d_write;
          addr_d     = d_address_in;
          wdata_d    = d_data_in;
          be_d       = d_write ? d_byte_en : '1;
          if (i_read) lose_cnt_d = lose_cnt_q + CNT_W'(1);
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          if (wr_q) begin
            d_valid_d = 1'b1;
            d_addr_d  = addr_q;
            state_d   = IDLE;
          end else begin
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (m_valid) begin
          if (owner_d_q) begin
            d_valid_d = 1'b1;
            d_data_d  = m_data_in;
            d_addr_d  = m_address_in;
          end else begin
            i_valid_d = 1'b1;
            i_data_d  = m_data_in;
            i_addr_d  = m_address_in;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lose_cnt_q <= '0;
      i_valid_q  <= 1'b0;
      i_data_q   <= '0;
      i_addr_q   <= '0;
      d_valid_q  <= 1'b0;
      d_data_q   <= '0;
      d_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lose_cnt_q <= lose_cnt_d;
      i_valid_q  <= i_valid_d;
      i_data_q   <= i_data_d;
      i_addr_q   <= i_addr_d;
      d_valid_q  <= d_valid_d;
      d_data_q   <= d_data_d;
      d_addr_q   <= d_addr_d;
    end
  end

  assign i_ready       = grant_i;
  assign d_ready       = grant_d;
  assign i_valid       = i_valid_q;
  assign i_data_out    = i_data_q;
  assign i_address_out = i_addr_q;
  assign d_valid       = d_valid_q;
  assign d_data_out    = d_data_q;
  assign d_address_out = d_addr_q;
  assign m_read        = (state_q == ISSUE) & ~wr_q;
  assign m_write       = (state_q == ISSUE) & wr_q;
  assign m_byte_en     = be_q;
  assign m_address_out = addr_q;
  assign m_data_out    = wdata_q;

endmodule

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Two-to-one arbiter that lets the fetch-side and memory-stage-side request ports of the memory interface share one single-ported memory or cache port. It captures one request at a time and issues it on the shared port. It waits for the response and routes it back to the owning requester. Data-side requests have priority, with a bounded-starvation guarantee for instruction fetch.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDRESS_BITS, 32, address bus width in bits
- MAX_WAIT, 4, consecutive contested losses the I side may suffer before it is forced to win (≥1)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  instruction read request; held until i_ready
- i_address_in  in  ADDRESS_BITS  instruction request address
- i_ready  out  1  I request accepted this cycle
- i_valid  out  1  one-cycle pulse: I response present
- i_data_out  out  DATA_WIDTH  I response data
- i_address_out  out  ADDRESS_BITS  I response address
- d_read, d_write  in  1 each  data request; held until d_ready
- d_byte_en  in  DATA_WIDTH/8  write byte enables
- d_address_in  in  ADDRESS_BITS  data request address
- d_data_in  in  DATA_WIDTH  write data
- d_ready  out  1  D request accepted this cycle
- d_valid  out  1  one-cycle pulse: D read data, or write acknowledge
- d_data_out  out  DATA_WIDTH  D read data
- d_address_out  out  ADDRESS_BITS  D response address
- m_read, m_write  out  1 each  shared-port request
- m_byte_en  out  DATA_WIDTH/8  shared-port byte enables
- m_address_out  out  ADDRESS_BITS  shared-port address
- m_data_out  out  DATA_WIDTH  shared-port write data
- m_ready  in  1  shared port accepts request this cycle
- m_valid  in  1  shared port read response valid
- m_data_in  in  DATA_WIDTH  shared port read data
- m_address_in  in  ADDRESS_BITS  shared port response address

## Operation
- **States.** IDLE, ISSUE, WAIT. Registers: owner (I/D), captured op/address/data/byte_en, and starvation counter `lose_cnt` (0..MAX_WAIT, saturating).
- **IDLE grant (combinational).** Computed from the request inputs.
  - Only one side requesting: that side is granted.
  - Both requesting: D is granted unless `lose_cnt == MAX_WAIT`, in which case I is granted.
- **On grant.**
  - Assert that side's ready in the same cycle.
  - Capture the request and go to ISSUE.
  - I grant clears `lose_cnt`.
  - A contested D grant increments `lose_cnt`.
  - An uncontested D grant leaves `lose_cnt` unchanged.
- **Request encoding.**
  - d_read and d_write both high is treated as a write.
  - Reads (I or D) drive `m_byte_en` all ones; writes drive the captured d_byte_en.
- **ISSUE.**
  - Drive m_read or m_write plus the captured fields; hold them until m_ready.
  - On m_ready with a read: go to WAIT.
  - On m_ready with a write: go to IDLE and pulse d_valid next cycle, with d_address_out = write address.
- **WAIT.** m_* request lines are low. On m_valid:
  - Register m_data_in and m_address_in into the owner's data_out/address_out.
  - Pulse the owner's valid next cycle.
  - Go to IDLE.
- **Ignored input.** m_valid in IDLE or ISSUE is ignored (no valid generated).
- **Held responses.** Response data/address outputs hold their last value until the next response to that side.
- **Ready signals.** i_ready/d_ready are only ever high in IDLE, never both.

## Timing
- **Reset.** State IDLE, `lose_cnt` 0, every output 0.
- **Reset mid-transaction.** Abandons the transaction; no valid is produced for it. A late m_valid after reset is ignored.
- **Read latency.** Request seen in IDLE at cycle t:
  - ready at t;
  - m_read at t+1;
  - if m_ready at t+1 and m_valid at t+1+k (k≥1), owner valid at t+2+k;
  - next grant possible in that same cycle t+2+k.
- **Write latency.** With m_ready at t+1, d_valid at t+2, and a new grant possible at t+2.
- **Throughput.** One outstanding transaction; peak one read per 3 cycles with k=1.
- **Starvation bound.** With both sides requesting continuously, I is served at least once every MAX_WAIT+1 grants.

## Test plan
- **Single I read.** i_read, addr 0x40, memory k=1 returns 0xDEADBEEF → i_ready at t, m_read at t+1, i_valid at t+3 with data 0xDEADBEEF and address 0x40.
- **D write.** d_write, addr 0x100, data 0x12345678, byte_en 4'b0011, m_ready held low 2 cycles → m_write held 3 cycles with same fields; d_valid one cycle after acceptance, d_address_out 0x100.
- **Contention, MAX_WAIT=4.** Both sides request continuously → grant order D,D,D,D,I,D,D,D,D,I; i_valid/d_valid data always matches the owner's address.
- **Illegal encoding and stray response.** d_read and d_write both high → m_write only. m_valid pulsed in IDLE → no i_valid/d_valid.
- **Reset mid-transaction.** Assert reset in WAIT, then deliver m_valid after release → no valid pulse, all outputs 0; next i_read is served normally.
